// File: rtl/dma_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dma_bus_arbiter_pkg
// Purpose : Shared definitions for the DMA bus arbiter. This includes the
//           arbiter state encodings, the STATE width and the counter
//           defaults. The CPU bus state machine and the LED logic decode
//           STATE from these same definitions.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package dma_bus_arbiter_pkg;

    localparam int unsigned STATE_W        = 3;
    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned MAX_TENURE_DEF = 16;
    localparam int unsigned HOLDOFF_DEF    = 4;

    typedef enum logic [STATE_W-1:0] {
        ARB_IDLE     = 3'd0,
        ARB_REQ      = 3'd1,
        ARB_WAIT_BUS = 3'd2,
        ARB_OWNED    = 3'd3,
        ARB_RELEASE  = 3'd4,
        ARB_HOLD     = 3'd5
    } arb_state_e;

endpackage : dma_bus_arbiter_pkg
`default_nettype wire

// File: rtl/dma_bus_arbiter_sync2.sv
`default_nettype none
// ============================================================================
// Module  : dma_bus_arbiter_sync2
// Purpose : Two-flop synchronizer for an asynchronous single-bit input.
//           The reset value can be set by parameter.
// Ports   : clk    - system clock, rising edge
//           rst_n  - asynchronous active-low reset
//           d_i    - asynchronous input
//           q_o    - synchronized output (2 clk latency)
// Rev     : 1.0  initial release
// ============================================================================
module dma_bus_arbiter_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : dma_bus_arbiter_sync2
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dma_bus_arbiter
// Purpose : 68030-style BR/BG/BGACK sequencer for the SDMAC DMA engine.
//           It requests the bus, waits for the previous master to finish,
//           and then lets the CPU bus state machine run cycles (GO).
//           Each tenure is bounded to MAX_TENURE completed cycles. After
//           BGACK is released, a HOLDOFF hold-off gives the host CPU the
//           bus back.
// Ports   : clk            - system clock, rising edge
//           rst_n          - asynchronous active-low reset
//           dmaena_i       - DMA enabled
//           dma_req_i      - engine wants the bus (level)
//           cycle_active_i - DMA bus cycle in progress, never cut
//           cycle_done_i   - one-clock pulse per completed DMA cycle
//           berr_ni        - bus error, async, active low
//           bg_ni          - bus grant, async, active low
//           as_ni          - address strobe on bus, async, active low
//           bgack_ni       - bus grant ack on bus, async, active low
//           br_o           - bus request, active high
//           own_o          - arbiter holds BGACK
//           go_o           - CPU bus state machine may start a cycle
//           tenure_end_o   - one-clock pulse when the tenure terminates
//           state_o        - current state encoding (debug/LEDs)
// Rev     : 1.0  initial release
// ============================================================================
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_TENURE = MAX_TENURE_DEF,
    parameter int unsigned HOLDOFF    = HOLDOFF_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dmaena_i,
    input  logic               dma_req_i,
    input  logic               cycle_active_i,
    input  logic               cycle_done_i,
    input  logic               berr_ni,
    input  logic               bg_ni,
    input  logic               as_ni,
    input  logic               bgack_ni,
    output logic               br_o,
    output logic               own_o,
    output logic               go_o,
    output logic               tenure_end_o,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] c_max_tenure    = CNT_W'(MAX_TENURE);
    localparam logic [CNT_W-1:0] c_last_tenure   = CNT_W'(MAX_TENURE - 1);
    localparam logic [CNT_W-1:0] c_last_holdoff  = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] c_one           = CNT_W'(1);

    // Synchronized bus pins, bit order: {berr, bgack, as, bg}
    logic [3:0] w_async;
    logic [3:0] w_sync;
    logic       w_bg;
    logic       w_as;
    logic       w_bgack;
    logic       w_berr;

    assign w_async = {berr_ni, bgack_ni, as_ni, bg_ni};

    for (genvar g = 0; g < 4; g++) begin : g_sync
        dma_bus_arbiter_sync2 #(
            .RST_VAL (1'b1)
        ) u_sync2 (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (w_async[g]),
            .q_o   (w_sync[g])
        );
    end

    assign w_bg    = w_sync[0];
    assign w_as    = w_sync[1];
    assign w_bgack = w_sync[2];
    assign w_berr  = w_sync[3];

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] tenure_q, tenure_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             w_req_ok;
    logic             w_exit;

    assign w_req_ok = dmaena_i & dma_req_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            tenure_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            tenure_q <= tenure_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tenure_d     = tenure_q;
        hold_d       = hold_q;
        br_o         = 1'b0;
        own_o        = 1'b0;
        go_o         = 1'b0;
        tenure_end_o = 1'b0;
        w_exit       = 1'b0;

        // The tenure count saturates at MAX_TENURE. A cycle that completes
        // after the exit decision (in RELEASE) still counts.
        if ((state_q == ARB_OWNED || state_q == ARB_RELEASE) &&
            cycle_done_i && (tenure_q < c_max_tenure)) begin
            tenure_d = tenure_q + c_one;
        end

        case (state_q)
            ARB_IDLE: begin
                if (w_req_ok) begin
                    state_d = ARB_REQ;
                end
            end

            ARB_REQ: begin
                br_o = 1'b1;
                if (!w_req_ok) begin
                    state_d = ARB_IDLE;
                end else if (!w_bg) begin
                    state_d = ARB_WAIT_BUS;
                end
            end

            ARB_WAIT_BUS: begin
                br_o = 1'b1;
                if (!dmaena_i) begin
                    state_d = ARB_IDLE;
                end else if (w_as && w_bgack) begin
                    state_d  = ARB_OWNED;
                    tenure_d = '0;
                end
            end

            ARB_OWNED: begin
                own_o  = 1'b1;
                // Any exit cause kills GO on the same clock. This stops the
                // CPU state machine from launching one more cycle.
                w_exit = !w_berr || !dmaena_i || !dma_req_i ||
                         (cycle_done_i && (tenure_q == c_last_tenure));
                if (w_exit) begin
                    state_d = ARB_RELEASE;
                end else begin
                    go_o = (tenure_q < c_max_tenure);
                end
            end

            ARB_RELEASE: begin
                own_o = 1'b1;
                // BGACK is held until the in-flight cycle has finished
                if (!cycle_active_i) begin
                    state_d      = ARB_HOLD;
                    tenure_end_o = 1'b1;
                    hold_d       = '0;
                end
            end

            ARB_HOLD: begin
                if (hold_q == c_last_holdoff) begin
                    state_d = ARB_IDLE;
                end else begin
                    hold_d = hold_q + c_one;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign state_o = state_q;

endmodule : dma_bus_arbiter
`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dma_bus_arbiter
// Purpose : Self-checking bench for dma_bus_arbiter. Expected output
//           snapshots {STATE, BR, OWN, GO, TENURE_END} are queued as
//           stimulus is applied. They are popped and compared when the DUT
//           reaches the corresponding point.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dma_bus_arbiter;
    import dma_bus_arbiter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       dmaena, dma_req, cycle_active, cycle_done;
    logic       berr_n, bg_n, as_n, bgack_n;
    logic       br, own, go, tenure_end;
    logic [2:0] state;
    logic [6:0] obs;

    typedef struct {
        string      n;
        logic [6:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    dma_bus_arbiter #(
        .MAX_TENURE (16),
        .HOLDOFF    (4),
        .CNT_W      (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dmaena_i       (dmaena),
        .dma_req_i      (dma_req),
        .cycle_active_i (cycle_active),
        .cycle_done_i   (cycle_done),
        .berr_ni        (berr_n),
        .bg_ni          (bg_n),
        .as_ni          (as_n),
        .bgack_ni       (bgack_n),
        .br_o           (br),
        .own_o          (own),
        .go_o           (go),
        .tenure_end_o   (tenure_end),
        .state_o        (state)
    );

    assign obs = {state, br, own, go, tenure_end};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ev(logic [2:0] st, logic b, logic o, logic g, logic t);
        return {st, b, o, g, t};
    endfunction

    function automatic void push(string n, logic [6:0] v);
        exp_t t;
        t.n = n;
        t.v = v;
        exp_q.push_back(t);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        dmaena = 1'b0; dma_req = 1'b0; cycle_active = 1'b0; cycle_done = 1'b0;
        berr_n = 1'b1; bg_n = 1'b1; as_n = 1'b1; bgack_n = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic get_bus(string name);
        int n;
        dmaena = 1'b1; dma_req = 1'b1; bg_n = 1'b0; as_n = 1'b1; bgack_n = 1'b1; berr_n = 1'b1;
        push(name, ev(ARB_OWNED, 1'b0, 1'b1, 1'b1, 1'b0));
        n = 0;
        while (state != ARB_OWNED && n < 10) begin step(); n++; end
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dmaena = 1'b1; dma_req = 1'b1; cycle_active = 1'b0; cycle_done = 1'b0;
        berr_n = 1'b1; bg_n = 1'b1; as_n = 1'b1; bgack_n = 1'b1;
        push("reset_held", ev(ARB_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        step(); step();
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        dmaena = 1'b0; dma_req = 1'b0;
        rst_n = 1'b1;
        push("reset_idle_after", ev(ARB_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        step(); step();
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
    endtask

    task automatic test_basic_tenure();
        int n;
        reset_dut();
        dmaena = 1'b1; dma_req = 1'b1;
        #1;
        push("basic_idle", ev(ARB_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        push("basic_br", ev(ARB_REQ, 1'b1, 1'b0, 1'b0, 1'b0));
        step();
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end

        bg_n = 1'b0;
        push("basic_owned", ev(ARB_OWNED, 1'b0, 1'b1, 1'b1, 1'b0));
        n = 0;
        while (state != ARB_OWNED && n < 8) begin step(); n++; end
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        checks++;
        if (n < 3 || n > 4) begin errors++; $display("FAIL basic_grant_latency: actual %0d clocks required 3..4", n); end

        cycle_active = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) push("basic_done16", ev(ARB_OWNED, 1'b0, 1'b1, 1'b0, 1'b0));
            else         push("basic_done",   ev(ARB_OWNED, 1'b0, 1'b1, 1'b1, 1'b0));
            cycle_done = 1'b1;
            #1;
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d]: actual %b required %b", e.n, k, obs, e.v); end
            step();
            cycle_done = 1'b0;
        end
        #1;
        push("basic_release", ev(ARB_RELEASE, 1'b0, 1'b1, 1'b0, 1'b0));
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        bg_n = 1'b1; cycle_active = 1'b0;
        #1;
        push("basic_tenure_end", ev(ARB_RELEASE, 1'b0, 1'b1, 1'b0, 1'b1));
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end

        step();
        push("basic_hold", ev(ARB_HOLD, 1'b0, 1'b0, 1'b0, 1'b0));
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        n = 0;
        while (state == ARB_HOLD && n < 20) begin step(); n++; end
        checks++;
        if (n != 4) begin errors++; $display("FAIL basic_hold_len: actual %0d clocks required 4", n); end
        push("basic_br_again", ev(ARB_REQ, 1'b1, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (!br && n < 8) begin step(); n++; end
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
    endtask

    task automatic test_bus_busy();
        int n;
        reset_dut();
        dmaena = 1'b1; dma_req = 1'b1; bg_n = 1'b0; as_n = 1'b0;
        n = 0;
        while (state != ARB_WAIT_BUS && n < 8) begin step(); n++; end
        for (int k = 0; k < 10; k++) begin
            push("busy_wait", ev(ARB_WAIT_BUS, 1'b1, 1'b0, 1'b0, 1'b0));
            step();
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d]: actual %b required %b", e.n, k, obs, e.v); end
        end
        as_n = 1'b1;
        push("busy_still_wait", ev(ARB_WAIT_BUS, 1'b1, 1'b0, 1'b0, 1'b0));
        push("busy_owned", ev(ARB_OWNED, 1'b0, 1'b1, 1'b1, 1'b0));
        step(); step();
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        step();
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
    endtask

    task automatic test_withdraw();
        reset_dut();
        dmaena = 1'b1; dma_req = 1'b1;
        push("withdraw_req", ev(ARB_REQ, 1'b1, 1'b0, 1'b0, 1'b0));
        step();
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        dma_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push("withdraw_idle", ev(ARB_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
            step();
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d]: actual %b required %b", e.n, k, obs, e.v); end
        end
    endtask

    task automatic test_early_stop();
        reset_dut();
        get_bus("early_owned");
        cycle_active = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push("early_go", ev(ARB_OWNED, 1'b0, 1'b1, 1'b1, 1'b0));
            cycle_done = 1'b1;
            #1;
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d]: actual %b required %b", e.n, k, obs, e.v); end
            step();
            cycle_done = 1'b0;
        end
        dma_req = 1'b0;
        #1;
        push("early_go_drop", ev(ARB_OWNED, 1'b0, 1'b1, 1'b0, 1'b0));
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        for (int k = 0; k < 2; k++) begin
            push("early_release", ev(ARB_RELEASE, 1'b0, 1'b1, 1'b0, 1'b0));
            step();
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s[%0d]: actual %b required %b", e.n, k, obs, e.v); end
        end
        cycle_active = 1'b0;
        #1;
        push("early_tenure_end", ev(ARB_RELEASE, 1'b0, 1'b1, 1'b0, 1'b1));
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        push("early_hold", ev(ARB_HOLD, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
    endtask

    task automatic test_bus_error();
        int  n;
        bit  go_seen;
        reset_dut();
        get_bus("berr_owned");
        berr_n = 1'b0;
        push("berr_sync1", ev(ARB_OWNED,   1'b0, 1'b1, 1'b1, 1'b0));
        push("berr_go_off", ev(ARB_OWNED,  1'b0, 1'b1, 1'b0, 1'b0));
        push("berr_release", ev(ARB_RELEASE, 1'b0, 1'b1, 1'b0, 1'b1));
        for (int k = 0; k < 3; k++) begin
            step();
            e = exp_q.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        end
        step();
        n = 0;
        go_seen = 1'b0;
        while (state == ARB_HOLD && n < 20) begin
            if (go || own) go_seen = 1'b1;
            step();
            n++;
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL berr_hold_len: actual %0d clocks required 4", n); end
        checks++;
        if (go_seen) begin errors++; $display("FAIL berr_no_go: actual go/own seen in HOLD required none"); end
        berr_n = 1'b1;
        dma_req = 1'b0;
    endtask

    task automatic test_async_reset();
        reset_dut();
        get_bus("arst_owned");
        #2;
        rst_n = 1'b0;
        #1;
        push("arst_immediate", ev(ARB_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: actual %b required %b", e.n, obs, e.v); end
        step();
        rst_n = 1'b1;
        get_bus("arst_restart");
    endtask

    initial begin
        test_reset();
        test_basic_tenure();
        test_bus_busy();
        test_withdraw();
        test_early_stop();
        test_bus_error();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d entries left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dma_bus_arbiter
`default_nettype wire
